bus_fabric: RTL and testbench

Parametrised data-bus interconnect replacing per-device busdev pairs and the hand-written read mux in the SoC toplevel. Decodes host read/write requests to NDEV devices, sequences them one at a time with an ack handshake, and returns registered read data. Flags unmapped accesses and stalled devices with an error status and a captured fault address. Sits between the core data port and all memory-mapped peripherals on cpuclk.

---
 rtl/bus_fabric_if.sv | 38 +++
 rtl/bus_fabric.sv | 176 +++++++++++++++++
 tb/tb_bus_fabric.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_fabric_if.sv
// Host and device signal bundle for the data-bus fabric.
// slave is the fabric's view; master is the host/device side.
interface bus_fabric_if #(
    parameter int NDEV = 4
);
    logic              r_en;
    logic [31:0]       r_addr;
    logic [31:0]       r_data;
    logic              r_valid;
    logic              w_en;
    logic [31:0]       w_addr;
    logic [31:0]       w_data;
    logic              busy;
    logic              err;
    logic              err_flag;
    logic [31:0]       err_addr;
    logic              err_clr;
    logic [NDEV-1:0]   dev_r_en;
    logic [NDEV-1:0]   dev_w_en;
    logic [31:0]       dev_addr;
    logic [31:0]       dev_w_data;
    logic [32*NDEV-1:0] dev_r_data;
    logic [NDEV-1:0]   dev_ack;

    modport slave (
        input  r_en, r_addr, w_en, w_addr, w_data, err_clr,
        input  dev_r_data, dev_ack,
        output r_data, r_valid, busy, err, err_flag, err_addr,
        output dev_r_en, dev_w_en, dev_addr, dev_w_data
    );

    modport master (
        output r_en, r_addr, w_en, w_addr, w_data, err_clr,
        output dev_r_data, dev_ack,
        input  r_data, r_valid, busy, err, err_flag, err_addr,
        input  dev_r_en, dev_w_en, dev_addr, dev_w_data
    );
endinterface

// File: rtl/bus_fabric.sv
// Data-bus interconnect: decodes host requests to NDEV windows,
// sequences one access at a time with ack/timeout and error capture.
module bus_fabric #(
    parameter int                 NDEV    = 4,
    parameter logic [32*NDEV-1:0] BASES   = {NDEV{32'h0}},
    parameter logic [5*NDEV-1:0]  WBITS   = {NDEV{5'd4}},
    parameter int                 TIMEOUT = 15
) (
    input logic        clk,
    input logic        rst,
    input logic        clk_enable,
    bus_fabric_if.slave bus
);
    localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state;
    logic            op_wr;
    logic [31:0]     op_addr;
    logic            op_hit;
    logic [IW-1:0]   op_idx;
    logic            pend_v;
    logic [31:0]     pend_addr;
    logic            pend_hit;
    logic [IW-1:0]   pend_idx;
    logic [7:0]      cnt;

    logic [31:0]     req_addr;
    logic            req_hit;
    logic [IW-1:0]   req_idx;
    logic            rd_hit;
    logic [IW-1:0]   rd_idx;
    logic            sel_ack;
    logic [31:0]     sel_rdata;
    logic            fin;
    logic            fin_err;

    function automatic logic match(input logic [31:0] a, input int i);
        int w;
        w = int'(WBITS[5*i +: 5]);
        return (a >> w) == (BASES[32*i +: 32] >> w);
    endfunction

    function automatic logic [31:0] wmask(input logic [IW-1:0] i);
        int w;
        w = int'(WBITS[5*int'(i) +: 5]);
        return (32'h1 << w) - 32'h1;
    endfunction

    function automatic logic [NDEV-1:0] onehot(input logic [IW-1:0] i);
        logic [NDEV-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scan high to low so the lowest matching index wins on overlap.
    always_comb begin
        req_addr = bus.w_en ? bus.w_addr : bus.r_addr;
        req_hit  = 1'b0;
        req_idx  = '0;
        rd_hit   = 1'b0;
        rd_idx   = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (match(req_addr, i)) begin
                req_hit = 1'b1;
                req_idx = IW'(i);
            end
            if (match(bus.r_addr, i)) begin
                rd_hit = 1'b1;
                rd_idx = IW'(i);
            end
        end
    end

    assign sel_ack   = op_hit && bus.dev_ack[op_idx];
    assign sel_rdata = bus.dev_r_data[32*int'(op_idx) +: 32];
    assign fin       = (state == ISSUE && (!op_hit || sel_ack)) ||
                       (state == WAIT && (sel_ack || cnt == TO_LAST));
    assign fin_err   = !sel_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            op_wr          <= 1'b0;
            op_addr        <= '0;
            op_hit         <= 1'b0;
            op_idx         <= '0;
            pend_v         <= 1'b0;
            pend_addr      <= '0;
            pend_hit       <= 1'b0;
            pend_idx       <= '0;
            cnt            <= '0;
            bus.r_data     <= '0;
            bus.r_valid    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.err        <= 1'b0;
            bus.err_flag   <= 1'b0;
            bus.err_addr   <= '0;
            bus.dev_r_en   <= '0;
            bus.dev_w_en   <= '0;
            bus.dev_addr   <= '0;
            bus.dev_w_data <= '0;
        end else begin
            bus.dev_r_en <= '0;
            bus.dev_w_en <= '0;
            bus.r_valid  <= 1'b0;
            bus.err      <= 1'b0;
            // A fault recorded below on the same edge overrides the clear.
            if (bus.err_clr) bus.err_flag <= 1'b0;
            if (clk_enable) begin
                unique case (state)
                    IDLE: begin
                        if (bus.w_en || bus.r_en) begin
                            op_wr     <= bus.w_en;
                            op_addr   <= req_addr;
                            op_hit    <= req_hit;
                            op_idx    <= req_idx;
                            bus.dev_addr <= req_hit ?
                                (req_addr & wmask(req_idx)) : '0;
                            if (bus.w_en) bus.dev_w_data <= bus.w_data;
                            if (req_hit && bus.w_en)
                                bus.dev_w_en <= onehot(req_idx);
                            if (req_hit && !bus.w_en)
                                bus.dev_r_en <= onehot(req_idx);
                            pend_v    <= bus.w_en && bus.r_en;
                            pend_addr <= bus.r_addr;
                            pend_hit  <= rd_hit;
                            pend_idx  <= rd_idx;
                            cnt       <= '0;
                            bus.busy  <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                    ISSUE, WAIT: begin
                        if (fin) begin
                            state       <= DONE;
                            bus.r_valid <= !op_wr;
                            bus.err     <= fin_err;
                            if (!op_wr)
                                bus.r_data <= fin_err ? '0 : sel_rdata;
                            if (fin_err) begin
                                bus.err_flag <= 1'b1;
                                bus.err_addr <= op_addr;
                            end
                        end else if (state == WAIT) begin
                            cnt <= cnt + 8'd1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    DONE: begin
                        if (pend_v) begin
                            pend_v  <= 1'b0;
                            op_wr   <= 1'b0;
                            op_addr <= pend_addr;
                            op_hit  <= pend_hit;
                            op_idx  <= pend_idx;
                            bus.dev_addr <= pend_hit ?
                                (pend_addr & wmask(pend_idx)) : '0;
                            if (pend_hit)
                                bus.dev_r_en <= onehot(pend_idx);
                            cnt     <= '0;
                            state   <= ISSUE;
                        end else begin
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: three devices, mapped, unmapped,
// zero-wait, slow, timeout, paired write/read, stall and reset cases.
module tb_bus_fabric;
    localparam int NDEV = 3;
    localparam logic [95:0] BASES = {32'h20, 32'h10, 32'h1000};
    localparam logic [14:0] WBITS = {5'd4, 5'd4, 5'd12};

    logic clk;
    logic rst;
    logic clk_enable;
    int   passed;
    int   total;
    int   n;
    int   busy_cnt;
    int   stb_cnt;
    int   rv_cnt;
    int   err_cnt;

    bus_fabric_if #(.NDEV(NDEV)) bus ();

    bus_fabric #(
        .NDEV(NDEV), .BASES(BASES), .WBITS(WBITS), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        clk_enable = 1'b1;
        bus.r_en = 1'b0;
        bus.r_addr = '0;
        bus.w_en = 1'b0;
        bus.w_addr = '0;
        bus.w_data = '0;
        bus.err_clr = 1'b0;
        bus.dev_r_data = '0;
        bus.dev_ack = '0;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rvalid", 32'(bus.r_valid), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_eflag", 32'(bus.err_flag), 0);
        chk("rst_eaddr", bus.err_addr, 0);
        chk("rst_rdata", bus.r_data, 0);
        chk("rst_strobes", 32'({bus.dev_r_en, bus.dev_w_en}), 0);
        chk("rst_daddr", bus.dev_addr, 0);
        rst = 1'b0;
        tick();

        // zero-wait read of dev0 window at 0x1000
        bus.r_en = 1'b1;
        bus.r_addr = 32'h1004;
        tick();
        bus.r_en = 1'b0;
        chk("rd0_stb", 32'(bus.dev_r_en), 32'b001);
        chk("rd0_wstb", 32'(bus.dev_w_en), 0);
        chk("rd0_addr", bus.dev_addr, 32'h4);
        chk("rd0_busy", 32'(bus.busy), 1);
        bus.dev_ack = 3'b001;
        bus.dev_r_data[31:0] = 32'hDEADBEEF;
        tick();
        bus.dev_ack = '0;
        chk("rd0_rvalid", 32'(bus.r_valid), 1);
        chk("rd0_rdata", bus.r_data, 32'hDEADBEEF);
        chk("rd0_stb_off", 32'(bus.dev_r_en), 0);
        chk("rd0_err", 32'(bus.err), 0);
        tick();
        chk("rd0_rv_end", 32'(bus.r_valid), 0);
        chk("rd0_idle", 32'(bus.busy), 0);

        // slow write to dev1: ack sampled 6 edges after the latch edge
        bus.w_en = 1'b1;
        bus.w_addr = 32'h14;
        bus.w_data = 32'hA5;
        tick();
        bus.w_en = 1'b0;
        chk("wr1_stb", 32'(bus.dev_w_en), 32'b010);
        chk("wr1_addr", bus.dev_addr, 32'h4);
        chk("wr1_data", bus.dev_w_data, 32'hA5);
        busy_cnt = int'(bus.busy);
        stb_cnt = int'(|bus.dev_w_en);
        rv_cnt = 0;
        err_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            bus.dev_ack = (c == 6) ? 3'b010 : 3'b000;
            tick();
            busy_cnt += int'(bus.busy);
            stb_cnt += int'(|bus.dev_w_en);
            rv_cnt += int'(bus.r_valid);
            err_cnt += int'(bus.err);
        end
        bus.dev_ack = '0;
        chk("wr1_busy_cyc", 32'(busy_cnt), 7);
        chk("wr1_stb_cyc", 32'(stb_cnt), 1);
        chk("wr1_no_rv", 32'(rv_cnt), 0);
        chk("wr1_no_err", 32'(err_cnt), 0);

        // unmapped read
        bus.r_en = 1'b1;
        bus.r_addr = 32'h4000;
        tick();
        bus.r_en = 1'b0;
        chk("um_no_stb", 32'(bus.dev_r_en), 0);
        tick();
        chk("um_err", 32'(bus.err), 1);
        chk("um_rvalid", 32'(bus.r_valid), 1);
        chk("um_rdata", bus.r_data, 0);
        chk("um_eflag", 32'(bus.err_flag), 1);
        chk("um_eaddr", bus.err_addr, 32'h4000);
        tick();
        chk("um_err_end", 32'(bus.err), 0);
        chk("um_sticky", 32'(bus.err_flag), 1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("um_clr", 32'(bus.err_flag), 0);

        // paired write (dev1) then pending read (dev0)
        bus.w_en = 1'b1;
        bus.w_addr = 32'h10;
        bus.w_data = 32'h77;
        bus.r_en = 1'b1;
        bus.r_addr = 32'h1008;
        tick();
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        chk("pr_wstb", 32'(bus.dev_w_en), 32'b010);
        chk("pr_rstb0", 32'(bus.dev_r_en), 0);
        chk("pr_waddr", bus.dev_addr, 0);
        bus.dev_ack = 3'b010;
        tick();
        bus.dev_ack = '0;
        chk("pr_wdone_rv", 32'(bus.r_valid), 0);
        chk("pr_busy1", 32'(bus.busy), 1);
        tick();
        chk("pr_rstb", 32'(bus.dev_r_en), 32'b001);
        chk("pr_raddr", bus.dev_addr, 32'h8);
        chk("pr_busy2", 32'(bus.busy), 1);
        bus.dev_ack = 3'b001;
        bus.dev_r_data[31:0] = 32'hCAFEF00D;
        tick();
        bus.dev_ack = '0;
        chk("pr_rvalid", 32'(bus.r_valid), 1);
        chk("pr_rdata", bus.r_data, 32'hCAFEF00D);
        chk("pr_busy3", 32'(bus.busy), 1);
        tick();
        chk("pr_rv_end", 32'(bus.r_valid), 0);
        chk("pr_idle", 32'(bus.busy), 0);

        // dev2 never acks; other devices ack and must be ignored
        bus.r_en = 1'b1;
        bus.r_addr = 32'h24;
        bus.dev_r_data[95:64] = 32'h12345678;
        tick();
        bus.r_en = 1'b0;
        chk("to_stb", 32'(bus.dev_r_en), 32'b100);
        bus.dev_ack = 3'b011;
        n = 0;
        while (!bus.err && n < 40) begin
            tick();
            n++;
        end
        bus.dev_ack = '0;
        chk("to_cycles", 32'(n), 16);
        chk("to_rvalid", 32'(bus.r_valid), 1);
        chk("to_rdata", bus.r_data, 0);
        chk("to_eaddr", bus.err_addr, 32'h24);
        chk("to_eflag", 32'(bus.err_flag), 1);
        tick();

        // stall mid-wait: counter frozen, ack ignored while disabled
        bus.r_en = 1'b1;
        bus.r_addr = 32'h14;
        bus.dev_r_data[63:32] = 32'h55AA;
        tick();
        bus.r_en = 1'b0;
        for (int c = 0; c < 11; c++) tick();
        clk_enable = 1'b0;
        bus.dev_ack = 3'b010;
        rv_cnt = 0;
        busy_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            rv_cnt += int'(bus.r_valid) + int'(bus.err);
            busy_cnt += int'(bus.busy);
        end
        chk("st_no_done", 32'(rv_cnt), 0);
        chk("st_busy", 32'(busy_cnt), 5);
        clk_enable = 1'b1;
        bus.dev_ack = '0;
        n = 0;
        while (!bus.err && n < 40) begin
            tick();
            n++;
        end
        chk("st_to_cycles", 32'(n), 5);
        chk("st_eaddr", bus.err_addr, 32'h14);
        tick();

        // stall then enable with ack held: accepted once enabled
        bus.r_en = 1'b1;
        bus.r_addr = 32'h18;
        tick();
        bus.r_en = 1'b0;
        tick();
        clk_enable = 1'b0;
        bus.dev_ack = 3'b010;
        rv_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            rv_cnt += int'(bus.r_valid);
        end
        chk("sa_no_rv", 32'(rv_cnt), 0);
        clk_enable = 1'b1;
        tick();
        bus.dev_ack = '0;
        chk("sa_rvalid", 32'(bus.r_valid), 1);
        chk("sa_rdata", bus.r_data, 32'h55AA);
        chk("sa_err", 32'(bus.err), 0);
        tick();

        // reset during WAIT
        bus.r_en = 1'b1;
        bus.r_addr = 32'h1004;
        tick();
        bus.r_en = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_busy", 32'(bus.busy), 0);
        chk("rw_err", 32'(bus.err), 0);
        chk("rw_rvalid", 32'(bus.r_valid), 0);
        chk("rw_stb", 32'(bus.dev_r_en), 0);
        chk("rw_eflag", 32'(bus.err_flag), 0);
        bus.dev_ack = 3'b001;
        rv_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            rv_cnt += int'(bus.r_valid) + int'(bus.err) + int'(bus.busy);
        end
        bus.dev_ack = '0;
        chk("rw_quiet", 32'(rv_cnt), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
